// File: rtl/id_stage_pipelined.sv
// RV32I decode into a registered ID/EX stage with one cycle of latency; load-use hazards insert counted bubbles.
// Backpressure: ex_ready low holds ID/EX and drops id_ready; flush kills ID/EX and refuses the presented instruction.
module id_stage_pipelined #(
  parameter int WORD_BITWIDTH       = 32,
  parameter int REG_NUM_BITWIDTH    = 5,
  parameter int BUBBLE_CNT_BITWIDTH = 16,
  parameter int HAZARD_EN           = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           if_valid,
  input  logic [WORD_BITWIDTH-1:0]       if_pc,
  input  logic [WORD_BITWIDTH-1:0]       if_instruction,
  output logic                           id_ready,
  input  logic                           flush,
  input  logic                           ex_ready,
  output logic                           ex_valid,
  output logic [WORD_BITWIDTH-1:0]       ex_pc,
  output logic [WORD_BITWIDTH-1:0]       ex_imm,
  output logic [REG_NUM_BITWIDTH-1:0]    ex_rs1,
  output logic [REG_NUM_BITWIDTH-1:0]    ex_rs2,
  output logic [REG_NUM_BITWIDTH-1:0]    ex_rd,
  output logic [6:0]                     ex_opcode,
  output logic [3:0]                     ex_inst_ALU,
  output logic                           ex_branch,
  output logic                           ex_jump,
  output logic                           ex_memRead,
  output logic                           ex_memToReg,
  output logic                           ex_memWrite,
  output logic                           ex_ALUSrc,
  output logic                           ex_regWrite,
  output logic [1:0]                     ex_ALUOp,
  output logic                           ex_illegal,
  output logic [BUBBLE_CNT_BITWIDTH-1:0] bubble_count
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef struct packed {
    logic       branch;
    logic       jump;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  logic [WORD_BITWIDTH-1:0]    ins;
  logic [6:0]                  dec_opcode;
  logic [REG_NUM_BITWIDTH-1:0] dec_rs1, dec_rs2, dec_rd;
  logic [WORD_BITWIDTH-1:0]    dec_imm;
  ctrl_t                       dec_ctrl;
  ctrl_t                       ex_ctrl;
  logic                        rs1_used, rs2_used;
  logic                        hazard, advance;

  assign ins        = if_instruction;
  assign dec_opcode = ins[6:0];
  assign dec_rd     = ins[7 +: REG_NUM_BITWIDTH];
  assign dec_rs1    = ins[15 +: REG_NUM_BITWIDTH];
  assign dec_rs2    = ins[20 +: REG_NUM_BITWIDTH];

  always_comb begin
    dec_ctrl = '0;
    dec_imm  = '0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (dec_opcode)
      OP_R: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = 2'b10;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OP_LOAD: begin
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.reg_write  = 1'b1;
        dec_imm  = {{20{ins[31]}}, ins[31:20]};
        rs1_used = 1'b1;
      end
      OP_IMM: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = 2'b11;
        dec_imm  = {{20{ins[31]}}, ins[31:20]};
        rs1_used = 1'b1;
      end
      OP_JALR: begin
        dec_ctrl.jump      = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_imm  = {{20{ins[31]}}, ins[31:20]};
        rs1_used = 1'b1;
      end
      OP_STORE: begin
        dec_ctrl.mem_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_imm  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OP_BR: begin
        dec_ctrl.branch = 1'b1;
        dec_ctrl.alu_op = 2'b01;
        dec_imm  = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_imm = {ins[31:12], 12'b0};
      end
      OP_JAL: begin
        dec_ctrl.jump      = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      default: dec_ctrl.illegal = 1'b1;
    endcase
  end

  // Only a load still sitting in ID/EX can be too late to forward from.
  assign hazard = (HAZARD_EN != 0) && ex_valid && ex_ctrl.mem_read && (ex_rd != '0) &&
                  ((rs1_used && (ex_rd == dec_rs1)) || (rs2_used && (ex_rd == dec_rs2))) &&
                  if_valid;
  assign advance  = !ex_valid || ex_ready;
  assign id_ready = advance && !hazard && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_imm       <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_opcode    <= '0;
      ex_inst_ALU  <= '0;
      ex_ctrl      <= '0;
      bubble_count <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (advance) begin
      if (hazard) begin
        ex_valid <= 1'b0;
        if (bubble_count != '1)
          bubble_count <= bubble_count + BUBBLE_CNT_BITWIDTH'(1);
      end else begin
        ex_valid <= if_valid;
        if (if_valid) begin
          ex_pc       <= if_pc;
          ex_imm      <= dec_imm;
          ex_rs1      <= dec_rs1;
          ex_rs2      <= dec_rs2;
          ex_rd       <= dec_rd;
          ex_opcode   <= dec_opcode;
          ex_inst_ALU <= {ins[30], ins[14:12]};
          ex_ctrl     <= dec_ctrl;
        end
      end
    end
  end

  assign ex_branch   = ex_ctrl.branch;
  assign ex_jump     = ex_ctrl.jump;
  assign ex_memRead  = ex_ctrl.mem_read;
  assign ex_memToReg = ex_ctrl.mem_to_reg;
  assign ex_memWrite = ex_ctrl.mem_write;
  assign ex_ALUSrc   = ex_ctrl.alu_src;
  assign ex_regWrite = ex_ctrl.reg_write;
  assign ex_ALUOp    = ex_ctrl.alu_op;
  assign ex_illegal  = ex_ctrl.illegal;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed and randomized checks of id_stage_pipelined against a behavioural pipeline model.
// A narrow bubble counter lets the randomized phase reach saturation.
module tb_id_stage_pipelined;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_valid;
  logic [31:0]   if_pc, if_instruction;
  logic          id_ready, flush, ex_ready, ex_valid;
  logic [31:0]   ex_pc, ex_imm;
  logic [4:0]    ex_rs1, ex_rs2, ex_rd;
  logic [6:0]    ex_opcode;
  logic [3:0]    ex_inst_ALU;
  logic          ex_branch, ex_jump, ex_memRead, ex_memToReg, ex_memWrite, ex_ALUSrc, ex_regWrite;
  logic [1:0]    ex_ALUOp;
  logic          ex_illegal;
  logic [BW-1:0] bubble_count;

  id_stage_pipelined #(.WORD_BITWIDTH(32), .REG_NUM_BITWIDTH(5), .BUBBLE_CNT_BITWIDTH(BW), .HAZARD_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_pc(if_pc), .if_instruction(if_instruction),
    .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_opcode(ex_opcode), .ex_inst_ALU(ex_inst_ALU), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_memRead(ex_memRead), .ex_memToReg(ex_memToReg), .ex_memWrite(ex_memWrite),
    .ex_ALUSrc(ex_ALUSrc), .ex_regWrite(ex_regWrite), .ex_ALUOp(ex_ALUOp),
    .ex_illegal(ex_illegal), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [31:0] pc, imm;
    logic [4:0] rs1, rs2, rd;
    logic [6:0] op;
    logic [3:0] alu;
    logic       br, jmp, mr, mtr, mw, src, rw;
    logic [1:0] aluop;
    logic       ill, u1, u2;
  } ex_t;

  ex_t           m;
  int            m_bub;
  int            compared = 0;
  int            mismatched = 0;
  logic          exp_rdy, obs_rdy;

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    logic signed [31:0] s;
    s = v << (32 - bits);
    s = s >>> (32 - bits);
    return s;
  endfunction

  function automatic ex_t decode(input logic [31:0] pc, input logic [31:0] ins);
    ex_t d;
    d = '{default: 0};
    d.valid = 1'b1;
    d.pc  = pc;
    d.op  = ins[6:0];
    d.rd  = ins[11:7];
    d.rs1 = ins[19:15];
    d.rs2 = ins[24:20];
    d.alu = {ins[30], ins[14:12]};
    case (ins[6:0])
      7'h33: begin d.rw = 1; d.aluop = 2'd2; d.u1 = 1; d.u2 = 1; end
      7'h03: begin d.mr = 1; d.mtr = 1; d.src = 1; d.rw = 1; d.u1 = 1; d.imm = sext(32'(ins[31:20]), 12); end
      7'h13: begin d.src = 1; d.rw = 1; d.aluop = 2'd3; d.u1 = 1; d.imm = sext(32'(ins[31:20]), 12); end
      7'h67: begin d.jmp = 1; d.rw = 1; d.src = 1; d.u1 = 1; d.imm = sext(32'(ins[31:20]), 12); end
      7'h23: begin d.mw = 1; d.src = 1; d.u1 = 1; d.u2 = 1; d.imm = sext(32'({ins[31:25], ins[11:7]}), 12); end
      7'h63: begin d.br = 1; d.aluop = 2'd1; d.u1 = 1; d.u2 = 1;
                   d.imm = sext(32'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13); end
      7'h37, 7'h17: begin d.src = 1; d.rw = 1; d.imm = ins & 32'hFFFFF000; end
      7'h6F: begin d.jmp = 1; d.rw = 1;
                   d.imm = sext(32'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21); end
      default: d.ill = 1;
    endcase
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(ex_valid), 32'(m.valid));
    chk({tag, ".pc"}, ex_pc, m.pc);
    chk({tag, ".imm"}, ex_imm, m.imm);
    chk({tag, ".regs"}, 32'({ex_rs1, ex_rs2, ex_rd}), 32'({m.rs1, m.rs2, m.rd}));
    chk({tag, ".op_alu"}, 32'({ex_opcode, ex_inst_ALU}), 32'({m.op, m.alu}));
    chk({tag, ".ctrl"},
        32'({ex_branch, ex_jump, ex_memRead, ex_memToReg, ex_memWrite, ex_ALUSrc, ex_regWrite, ex_ALUOp, ex_illegal}),
        32'({m.br, m.jmp, m.mr, m.mtr, m.mw, m.src, m.rw, m.aluop, m.ill}));
    chk({tag, ".bubbles"}, 32'(bubble_count), 32'(m_bub));
  endtask

  task automatic model_reset();
    m = '{default: 0};
    m_bub = 0;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic fl, input logic er);
    if_valid = v; if_pc = pc; if_instruction = ins; flush = fl; ex_ready = er;
  endtask

  // Called just after an edge with inputs already driven; advances one clock.
  task automatic cycle(input string tag);
    ex_t  d;
    logic haz, adv;
    #1;
    d   = decode(if_pc, if_instruction);
    haz = m.valid && m.mr && (m.rd != 0) &&
          ((d.u1 && m.rd == d.rs1) || (d.u2 && m.rd == d.rs2)) && if_valid;
    adv = !m.valid || ex_ready;
    exp_rdy = adv && !haz && !flush;
    obs_rdy = id_ready;
    chk({tag, ".id_ready"}, 32'(id_ready), 32'(exp_rdy));
    @(posedge clk);
    if (flush) m.valid = 1'b0;
    else if (adv && haz) begin
      m.valid = 1'b0;
      if (m_bub < (1 << BW) - 1) m_bub++;
    end else if (adv) begin
      if (if_valid) m = d;
      else m.valid = 1'b0;
    end
    #1;
    check_all(tag);
  endtask

  task automatic issue(input string tag, input logic [31:0] pc, input logic [31:0] ins);
    drive(1'b1, pc, ins, 1'b0, 1'b1);
    cycle(tag);
  endtask

  function automatic logic [31:0] rnd_ins();
    logic [31:0] ins;
    logic [6:0]  ops [12];
    ops = '{7'h33, 7'h03, 7'h03, 7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
    ins = $urandom;
    ins[6:0]   = ops[$urandom_range(0, 11)];
    ins[11:7]  = 5'($urandom_range(0, 3));
    ins[19:15] = 5'($urandom_range(0, 3));
    ins[24:20] = 5'($urandom_range(0, 3));
    return ins;
  endfunction

  initial begin
    logic [31:0] cur_pc, cur_ins, held_pc;
    logic        cur_v, fl;
    int          saved_bub;

    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue("addi", 32'h100, 32'hFFF00093);
    chk("addi.imm_k", ex_imm, 32'hFFFFFFFF);
    chk("addi.aluop_rw_k", 32'({ex_ALUOp, ex_regWrite}), 32'h7);
    issue("lui", 32'h104, 32'h123450B7);
    chk("lui.imm_k", ex_imm, 32'h12345000);
    issue("jal", 32'h108, 32'h0000006F);
    chk("jal.imm_jump_k", 32'({ex_imm[3:0], ex_jump}), 32'h1);
    issue("beq", 32'h10C, 32'hFE000EE3);
    chk("beq.imm_k", ex_imm, 32'hFFFFFFFC);
    chk("beq.branch_k", 32'(ex_branch), 32'h1);

    issue("lw_x5", 32'h110, 32'h0000A283);
    drive(1'b1, 32'h114, 32'h00228333, 1'b0, 1'b1);
    cycle("lu_stall");
    chk("lu_stall.rdy_k", 32'(obs_rdy), 32'h0);
    chk("lu_stall.vld_k", 32'(ex_valid), 32'h0);
    chk("lu_stall.bub_k", 32'(bubble_count), 32'h1);
    cycle("lu_issue");
    chk("lu_issue.rdy_k", 32'(obs_rdy), 32'h1);
    chk("lu_issue.pc_k", ex_pc, 32'h114);

    issue("lw_x0", 32'h118, 32'h0000A003);
    issue("add_x0", 32'h11C, 32'h00000333);
    chk("nohaz_x0.rdy_k", 32'(obs_rdy), 32'h1);
    issue("lw_x5b", 32'h120, 32'h0000A283);
    issue("lui_x5", 32'h124, 32'h000052B7);
    chk("nohaz_lui.rdy_k", 32'(obs_rdy), 32'h1);
    chk("nohaz.bub_k", 32'(bubble_count), 32'h1);

    issue("bp_addi", 32'h128, 32'h00138393);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h12C, 32'h00140413, 1'b0, 1'b0);
      cycle("bp_hold");
      chk("bp_hold.rdy_k", 32'(obs_rdy), 32'h0);
      chk("bp_hold.pc_k", ex_pc, 32'h128);
    end
    drive(1'b1, 32'h12C, 32'h00140413, 1'b0, 1'b1);
    cycle("bp_release");
    chk("bp_release.pc_k", ex_pc, 32'h12C);

    issue("fl_lw", 32'h130, 32'h0000A283);
    saved_bub = 32'(bubble_count);
    drive(1'b1, 32'h134, 32'h00228333, 1'b1, 1'b1);
    cycle("flush");
    chk("flush.rdy_k", 32'(obs_rdy), 32'h0);
    chk("flush.vld_k", 32'(ex_valid), 32'h0);
    chk("flush.bub_k", 32'(bubble_count), 32'(saved_bub));

    issue("illegal", 32'h200, 32'h0000007F);
    chk("illegal.flag_k", 32'({ex_valid, ex_illegal}), 32'h3);
    chk("illegal.ctrl_k",
        32'({ex_branch, ex_jump, ex_memRead, ex_memToReg, ex_memWrite, ex_ALUSrc, ex_regWrite, ex_ALUOp}), 32'h0);

    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("mid_reset");
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    cur_v   = 1'b1;
    cur_pc  = 32'h1000;
    cur_ins = rnd_ins();
    for (int i = 0; i < 1500; i++) begin
      fl = ($urandom_range(0, 15) == 0);
      drive(cur_v, cur_pc, cur_ins, fl, $urandom_range(0, 3) != 0);
      held_pc = cur_pc;
      cycle("rnd");
      if (!cur_v || exp_rdy || fl) begin
        cur_v   = ($urandom_range(0, 3) != 0);
        cur_pc  = held_pc + 32'd4;
        cur_ins = rnd_ins();
      end
    end
    chk("rnd.bub_saturated_k", 32'(bubble_count), 32'((1 << BW) - 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
